// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with MEM/WB operand forwarding.
// Holds the decoded instruction for the EX stage. Forwarding resolves RAW
// hazards against the MEM and WB producers. The stage drives the ALU's
// A/B/op inputs and the forwarded store data.
module ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_valid,
    input  logic [2:0]       id_alu_op,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_shamt,
    input  logic             id_alu_src,
    input  logic             id_shift,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [REGW-1:0]  id_rd,
    input  logic             id_reg_write,

    input  logic             stall,
    input  logic             flush,

    input  logic             mem_reg_write,
    input  logic [REGW-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_reg_write,
    input  logic [REGW-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_result,

    output logic             ex_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] ex_rt_fwd,
    output logic [REGW-1:0]  ex_rd,
    output logic             ex_reg_write
);

    logic             valid_q;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] rs_data_q;
    logic [WIDTH-1:0] rt_data_q;
    logic [WIDTH-1:0] imm_q;
    logic [4:0]       shamt_q;
    logic             alu_src_q;
    logic             shift_q;
    logic [REGW-1:0]  rs_q;
    logic [REGW-1:0]  rt_q;
    logic [REGW-1:0]  rd_q;
    logic             reg_write_q;

    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    // Forward the youngest in-flight producer (MEM before WB); $0 is never forwarded
    always_comb begin
        fwd_rs = rs_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs_q)) begin
            fwd_rs = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_q)) begin
            fwd_rs = wb_result;
        end

        fwd_rt = rt_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rt_q)) begin
            fwd_rt = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_q)) begin
            fwd_rt = wb_result;
        end
    end

    // Pipeline register: flush beats stall; a stall refreshes the operand data so a retiring producer is not lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_op_q    <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            alu_src_q   <= 1'b0;
            shift_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            alu_op_q    <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            alu_src_q   <= 1'b0;
            shift_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (stall) begin
            rs_data_q   <= fwd_rs;
            rt_data_q   <= fwd_rt;
        end else begin
            valid_q     <= id_valid;
            alu_op_q    <= id_alu_op;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            shamt_q     <= id_shamt;
            alu_src_q   <= id_alu_src;
            shift_q     <= id_shift;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            rd_q        <= id_rd;
            reg_write_q <= id_reg_write & id_valid;
        end
    end

    // ALU operand selection: shifts take rt as A and the zero-extended shamt as B
    always_comb begin
        if (shift_q) begin
            alu_a = fwd_rt;
            alu_b = {{(WIDTH-5){1'b0}}, shamt_q};
        end else begin
            alu_a = fwd_rs;
            alu_b = alu_src_q ? imm_q : fwd_rt;
        end
    end

    assign ex_valid     = valid_q;
    assign alu_op       = alu_op_q;
    assign ex_rt_fwd    = fwd_rt;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed test of the ID/EX operand stage against an
// instruction-level model of the EX slot, checked every cycle, plus literal checks.
module tb_ex_operand_stage;

    localparam int WIDTH = 32;
    localparam int REGW  = 5;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [2:0]       id_alu_op;
    logic [WIDTH-1:0] id_rs_data;
    logic [WIDTH-1:0] id_rt_data;
    logic [WIDTH-1:0] id_imm;
    logic [4:0]       id_shamt;
    logic             id_alu_src;
    logic             id_shift;
    logic [REGW-1:0]  id_rs;
    logic [REGW-1:0]  id_rt;
    logic [REGW-1:0]  id_rd;
    logic             id_reg_write;
    logic             stall;
    logic             flush;
    logic             mem_reg_write;
    logic [REGW-1:0]  mem_rd;
    logic [WIDTH-1:0] mem_result;
    logic             wb_reg_write;
    logic [REGW-1:0]  wb_rd;
    logic [WIDTH-1:0] wb_result;
    logic             ex_valid;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] ex_rt_fwd;
    logic [REGW-1:0]  ex_rd;
    logic             ex_reg_write;

    int checks = 0;
    int errors = 0;

    ex_operand_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alu_src(id_alu_src), .id_shift(id_shift),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write),
        .stall(stall), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_rt_fwd(ex_rt_fwd), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction currently occupying the EX slot, as the model sees it
    typedef struct packed {
        logic             valid;
        logic [2:0]       op;
        logic [WIDTH-1:0] rsData;
        logic [WIDTH-1:0] rtData;
        logic [WIDTH-1:0] imm;
        logic [4:0]       shamt;
        logic             aluSrc;
        logic             shift;
        logic [REGW-1:0]  rs;
        logic [REGW-1:0]  rt;
        logic [REGW-1:0]  rd;
        logic             regWrite;
    } exSlot_t;

    exSlot_t model;

    // Value register 'spec' currently holds, as the youngest in-flight producer sees it
    function automatic logic [WIDTH-1:0] operandValue(input logic [REGW-1:0] spec,
                                                      input logic [WIDTH-1:0] fileValue);
        if (spec == 0) return fileValue;
        if (mem_reg_write && mem_rd == spec) return mem_result;
        if (wb_reg_write && wb_rd == spec) return wb_result;
        return fileValue;
    endfunction

    // Model of the EX slot: reset/flush empty it, stall keeps it with fresh operands, else take ID
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model = '0;
        end else if (flush) begin
            model = '0;
        end else if (stall) begin
            model.rsData = operandValue(model.rs, model.rsData);
            model.rtData = operandValue(model.rt, model.rtData);
        end else begin
            model.valid    = id_valid;
            model.op       = id_alu_op;
            model.rsData   = id_rs_data;
            model.rtData   = id_rt_data;
            model.imm      = id_imm;
            model.shamt    = id_shamt;
            model.aluSrc   = id_alu_src;
            model.shift    = id_shift;
            model.rs       = id_rs;
            model.rt       = id_rt;
            model.rd       = id_rd;
            model.regWrite = id_valid && id_reg_write;
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, away from the active edge, compare the DUT to the model
    always @(negedge clk) begin
        logic [WIDTH-1:0] rsVal;
        logic [WIDTH-1:0] rtVal;
        rsVal = operandValue(model.rs, model.rsData);
        rtVal = operandValue(model.rt, model.rtData);
        checkOutput("cyc_ex_valid", {31'b0, ex_valid}, {31'b0, model.valid});
        checkOutput("cyc_alu_op", {29'b0, alu_op}, {29'b0, model.op});
        checkOutput("cyc_alu_a", alu_a, model.shift ? rtVal : rsVal);
        checkOutput("cyc_alu_b", alu_b,
                    model.shift ? {27'b0, model.shamt} : (model.aluSrc ? model.imm : rtVal));
        checkOutput("cyc_rt_fwd", ex_rt_fwd, rtVal);
        checkOutput("cyc_ex_rd", {27'b0, ex_rd}, {27'b0, model.rd});
        checkOutput("cyc_reg_write", {31'b0, ex_reg_write}, {31'b0, model.regWrite});
    end

    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [WIDTH-1:0] rsd, input logic [WIDTH-1:0] rtd,
                                 input logic [WIDTH-1:0] imm, input logic [4:0] sh,
                                 input logic src, input logic shf,
                                 input logic [REGW-1:0] rs, input logic [REGW-1:0] rt,
                                 input logic [REGW-1:0] rd, input logic rw);
        id_valid     = v;
        id_alu_op    = op;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_imm       = imm;
        id_shamt     = sh;
        id_alu_src   = src;
        id_shift     = shf;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_reg_write = rw;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
        wb_reg_write  = 1'b0; wb_rd  = '0; wb_result  = '0;
        applyStimulus(1'b0, 3'b000, '0, '0, '0, 5'd0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #2;
        checkOutput("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("reset_alu_op", {29'b0, alu_op}, 32'd0);
        checkOutput("reset_reg_write", {31'b0, ex_reg_write}, 32'd0);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;

        // Plain capture
        applyStimulus(1'b1, 3'b001, 32'd5, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
        stepCycle();
        checkOutput("plain_alu_a", alu_a, 32'd5);
        checkOutput("plain_alu_b", alu_b, 32'd3);
        checkOutput("plain_alu_op", {29'b0, alu_op}, 32'd1);
        checkOutput("plain_ex_valid", {31'b0, ex_valid}, 32'd1);

        // Invalid instruction must not write
        applyStimulus(1'b0, 3'b010, 32'd7, 32'd8, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
        stepCycle();
        checkOutput("invalid_reg_write", {31'b0, ex_reg_write}, 32'd0);

        // Forward priority: MEM over WB, then WB alone, then $0 never forwarded
        applyStimulus(1'b1, 3'b000, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0, 5'd8, 5'd0, 5'd4, 1'b1);
        mem_reg_write = 1'b1; mem_rd = 5'd8; mem_result = 32'h11;
        wb_reg_write  = 1'b1; wb_rd  = 5'd8; wb_result  = 32'h22;
        stepCycle();
        checkOutput("fwd_mem_wins", alu_a, 32'h11);
        mem_reg_write = 1'b0;
        #1;
        checkOutput("fwd_wb_only", alu_a, 32'h22);
        applyStimulus(1'b1, 3'b000, 32'h77, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1);
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'h55;
        wb_reg_write  = 1'b1; wb_rd  = 5'd0; wb_result  = 32'h66;
        stepCycle();
        checkOutput("fwd_reg0_blocked", alu_a, 32'h77);
        checkOutput("fwd_reg0_rt", ex_rt_fwd, 32'd2);

        // Stall refresh: producer leaves MEM, passes WB, then retires
        wb_reg_write = 1'b0;
        applyStimulus(1'b1, 3'b000, 32'h01, 32'h02, 32'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd10, 5'd11, 1'b1);
        mem_reg_write = 1'b1; mem_rd = 5'd9; mem_result = 32'hAA;
        stepCycle();
        checkOutput("stall_capture", alu_a, 32'hAA);
        stall = 1'b1;
        applyStimulus(1'b1, 3'b011, 32'h33, 32'h44, 32'd0, 5'd0, 1'b0, 1'b0, 5'd12, 5'd13, 5'd14, 1'b1);
        stepCycle();
        mem_reg_write = 1'b0;
        wb_reg_write  = 1'b1; wb_rd = 5'd9; wb_result = 32'hAA;
        #1;
        checkOutput("stall_in_wb", alu_a, 32'hAA);
        stepCycle();
        wb_reg_write = 1'b0;
        #1;
        checkOutput("stall_retired", alu_a, 32'hAA);
        stepCycle();
        stall = 1'b0;
        #1;
        checkOutput("stall_release_a", alu_a, 32'hAA);
        checkOutput("stall_release_op", {29'b0, alu_op}, 32'd0);
        checkOutput("stall_release_rd", {27'b0, ex_rd}, 32'd11);
        stepCycle();

        // Flush wins over stall
        applyStimulus(1'b1, 3'b011, 32'h5, 32'h6, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
        stall = 1'b1; flush = 1'b1;
        stepCycle();
        stall = 1'b0; flush = 1'b0;
        checkOutput("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("flush_reg_write", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("flush_alu_op", {29'b0, alu_op}, 32'd0);

        // Shift and immediate operand selection
        applyStimulus(1'b1, 3'b101, 32'h1234, 32'h80000000, 32'h99, 5'd4, 1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 1'b1);
        stepCycle();
        checkOutput("shift_alu_a", alu_a, 32'h80000000);
        checkOutput("shift_alu_b", alu_b, 32'd4);
        checkOutput("shift_alu_op", {29'b0, alu_op}, 32'd5);
        applyStimulus(1'b1, 3'b000, 32'h10, 32'h3, 32'hFFFFFFFC, 5'd0, 1'b1, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1);
        stepCycle();
        checkOutput("imm_alu_a", alu_a, 32'h10);
        checkOutput("imm_alu_b", alu_b, 32'hFFFFFFFC);
        checkOutput("imm_rt_fwd", ex_rt_fwd, 32'h3);

        // Asynchronous reset mid-stream
        applyStimulus(1'b1, 3'b010, 32'h21, 32'h22, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
        stepCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("async_rst_op", {29'b0, alu_op}, 32'd0);
        checkOutput("async_rst_rw", {31'b0, ex_reg_write}, 32'd0);
        stepCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_valid", {31'b0, ex_valid}, 32'd0);
        stepCycle();
        checkOutput("resume_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("resume_op", {29'b0, alu_op}, 32'd2);
        checkOutput("resume_alu_a", alu_a, 32'h21);

        stepCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
